dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, single clock domain.
- Independent write and read addresses, so a write and a read can occur in the same cycle.
- Used as a small register-file/buffer store, default 16 words x 8 bits.
- Asynchronous active-low reset clears the array and the output register.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16 by default).

Ports:
- clk  input  1  clock; all state updates occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Data_in  input  DATA_WIDTH  write data.
- Addr_wr  input  ADDR_WIDTH  write address.
- wr_en  input  1  write enable, active high.
- Data_out  output  DATA_WIDTH  registered read data.
- Addr_rd  input  ADDR_WIDTH  read address.
- rd_en  input  1  read enable, active high.
- rd_valid  output  1  high for the cycle in which Data_out carries data from a read accepted on the previous edge.
- Instance port order: clk, Data_in, Addr_wr, wr_en, Data_out, Addr_rd, rd_en, then rst_n, rd_valid.

Behaviour:
- One clock; reset is asynchronous and active-low.

Reset:
- rst_n low immediately forces every memory word to 0, Data_out to 0 and rd_valid to 0, independent of clk.
- While rst_n is low, writes and reads are ignored.
- Release is sampled at the next rising edge; the first write or read can occur on that edge.
- Reset asserted mid-operation discards any pending read result and clears all stored data.

Write:
- On rising clk with wr_en=1: mem[Addr_wr] <= Data_in.
- wr_en=0: memory unchanged.
- Write has no visible output.

Read:
- On rising clk with rd_en=1: Data_out <= mem[Addr_rd] and rd_valid <= 1.
- Latency is one cycle: data is visible after the same edge that samples rd_en and Addr_rd.
- rd_en=0: Data_out holds its previous value and rd_valid <= 0.

Simultaneous write and read:
- Different addresses: both complete independently in the same cycle.
- Same address (rd_en=1, wr_en=1, Addr_rd==Addr_wr): write-first. Data_out <= Data_in (new data forwarded) and the memory is updated.

Boundaries:
- Addresses cover the full range 0..2**ADDR_WIDTH-1; no out-of-range case exists and there is no wrap logic.
- Reading a never-written location after reset returns 0.
- Back-to-back writes and reads every cycle are supported with no stall; there is no ready/backpressure.
- Enables held high with constant inputs repeat the operation each cycle: idempotent for writes, Data_out refreshed for reads.
- X/Z on the address while its enable is low must not corrupt state.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle -> Data_out=0x00 and rd_valid=0 immediately. Then read addresses 0..15 -> all return 0x00.
2. Sequential fill: write mem[i]=i*17 for i=0..15 on consecutive edges (0x00, 0x11, ..., 0xFF). Then read j=0..15 on consecutive edges -> Data_out=j*17 one cycle after each read, rd_valid=1 throughout.
3. Overlapped streams: start the write stream of random data at cycle 0 and the read stream of 0..15 at cycle 1, with the read address lagging the write by one -> every read returns the data written to that address the prior cycle.
4. Same-address collision: mem[5]=0x3C; same edge wr_en=1, Addr_wr=5, Data_in=0xA7, rd_en=1, Addr_rd=5 -> Data_out=0xA7. A subsequent read of 5 -> 0xA7.
5. Hold behaviour:
   - Read addr 2 (=0x22), then rd_en=0 for 3 cycles while writing addr 2=0x99 -> Data_out stays 0x22 and rd_valid=0.
   - Then read addr 2 -> 0x99.
6. Reset mid-operation: fill memory, assert rst_n=0 for half a cycle during a read burst -> Data_out=0 immediately. After release, reading addr 7 -> 0x00.

Source files
------------

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Same-address collisions are write-first; reset clears array and read output.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic [ADDR_WIDTH-1:0] Addr_wr,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] Data_out,
  input  logic [ADDR_WIDTH-1:0] Addr_rd,
  input  logic                  rd_en,
  input  logic                  rst_n,
  output logic                  rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  fwd;

  assign fwd = wr_en && (Addr_wr == Addr_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      Data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en)
        mem[Addr_wr] <= Data_in;
      // forward new data when reading the word being written
      if (rd_en)
        Data_out <= fwd ? Data_in : mem[Addr_rd];
      rd_valid <= rd_en;
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: reads push expected data,
// the registered output is popped and compared one edge later.
module tb_dual_port_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] Data_in = '0;
  logic [3:0] Addr_wr = '0;
  logic       wr_en = 1'b0;
  logic [7:0] Data_out;
  logic [3:0] Addr_rd = '0;
  logic       rd_en = 1'b0;
  logic       rd_valid;

  logic [7:0] model [16];
  logic [7:0] q [$];
  logic [7:0] exp_dout;
  logic       exp_valid;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .Data_in  (Data_in),
    .Addr_wr  (Addr_wr),
    .wr_en    (wr_en),
    .Data_out (Data_out),
    .Addr_rd  (Addr_rd),
    .rd_en    (rd_en),
    .rst_n    (rst_n),
    .rd_valid (rd_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 16; i++)
      model[i] = 8'h00;
    q.delete();
    exp_dout = 8'h00;
  endtask

  task automatic op(input logic       we,
                    input logic [3:0] wa,
                    input logic [7:0] wd,
                    input logic       re,
                    input logic [3:0] ra);
    logic [7:0] e;
    wr_en   = we;
    Data_in = wd;
    Addr_wr = we ? wa : 4'bxxxx;
    rd_en   = re;
    Addr_rd = re ? ra : 4'bxxxx;
    exp_valid = re;
    if (re) begin
      e = (we && wa == ra) ? wd : model[ra];
      q.push_back(e);
      exp_dout = e;
    end
    if (we)
      model[wa] = wd;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      if (q.size() == 0)
        chk("queue", 32'd0, 32'd1);
      else
        chk("rdata", {24'd0, Data_out}, {24'd0, q.pop_front()});
    end else begin
      chk("hold", {24'd0, Data_out}, {24'd0, exp_dout});
    end
  endtask

  task automatic idle();
    op(1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
  endtask

  initial begin
    clr_model();
    exp_valid = 1'b0;

    // reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", {24'd0, Data_out}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 16; j++)
      op(1'b0, 4'd0, 8'd0, 1'b1, 4'(j));

    // sequential fill and readback
    for (int i = 0; i < 16; i++)
      op(1'b1, 4'(i), 8'(i * 17), 1'b0, 4'd0);
    for (int j = 0; j < 16; j++)
      op(1'b0, 4'd0, 8'd0, 1'b1, 4'(j));

    // overlapped streams, read lags write by one
    op(1'b1, 4'd0, 8'($urandom_range(0, 255)), 1'b0, 4'd0);
    for (int k = 1; k < 16; k++)
      op(1'b1, 4'(k), 8'($urandom_range(0, 255)), 1'b1, 4'(k - 1));
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd15);

    // same-address collision
    op(1'b1, 4'd5, 8'h3C, 1'b0, 4'd0);
    op(1'b1, 4'd5, 8'hA7, 1'b1, 4'd5);
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd5);

    // hold while writing underneath
    op(1'b1, 4'd2, 8'h22, 1'b0, 4'd0);
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
    repeat (3) op(1'b1, 4'd2, 8'h99, 1'b0, 4'd0);
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
    idle();

    // reset during a read burst
    for (int i = 0; i < 16; i++)
      op(1'b1, 4'(i), 8'(i * 17) | 8'h01, 1'b0, 4'd0);
    for (int j = 0; j < 4; j++)
      op(1'b0, 4'd0, 8'd0, 1'b1, 4'(j + 4));
    rd_en = 1'b1;
    Addr_rd = 4'd9;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", {24'd0, Data_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    #3 rst_n = 1'b1;
    clr_model();
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd7);
    op(1'b0, 4'd0, 8'd0, 1'b1, 4'd15);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
